l0_pool_ctrl: RTL and testbench

Sequencer for the layer-0 feature-map RAM (26x26 entries, 18-bit, 2x2 combinational window read). Fills the RAM from the upstream convolution stream in raster order. Then scans it with stride 2, presenting 169 non-overlapping 2x2 windows to the downstream max-pool stage over a valid/ready handshake. Sits between the conv-0 output and the pool-0 comparator.

---
 rtl/cnn_l0_pkg.sv | 24 ++
 rtl/l0_pool_addr_gen.sv | 68 ++++++
 rtl/l0_pool_ctrl.sv | 151 +++++++++++++++
 tb/tb_l0_pool_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_l0_pkg.sv
// ---------------------------------------------------------------------------
// cnn_l0_pkg
// Shared constants and types for the layer-0 feature-map / pool-0 path.
//   FMAP_W : feature-map side length (26)
//   POOL_W : pooled output side length (FMAP_W/2 = 13)
//   DATA_W : pixel width (18)
//   ADDR_W : feature-map RAM address width (10)
//   l0_ctrl_state_t : sequencer state encoding
// ---------------------------------------------------------------------------
package cnn_l0_pkg;

    localparam int FMAP_W = 26;
    localparam int POOL_W = FMAP_W / 2;
    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } l0_ctrl_state_t;

endpackage

// File: rtl/l0_pool_addr_gen.sv
// ---------------------------------------------------------------------------
// l0_pool_addr_gen
// Walks the pooled output grid (row, col) and the matching RAM read address
// of the bottom-right pixel of each 2x2 window.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_clear       : load the first window (row=col=0, addr=FMAP_W+1)
//   i_advance     : step to the next window (ignored on the last window)
//   o_addr        : RAM read address, (2*row+1)*FMAP_W + (2*col+1)
//   o_row, o_col  : pooled coordinate
//   o_last        : current window is the final one of the frame
// ---------------------------------------------------------------------------
module l0_pool_addr_gen #(
    parameter int FMAP_W = cnn_l0_pkg::FMAP_W,
    parameter int ADDR_W = cnn_l0_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_row,
    output logic [3:0]        o_col,
    output logic              o_last
);
    import cnn_l0_pkg::*;

    localparam logic [3:0]        LAST_RC  = 4'(FMAP_W / 2 - 1);
    localparam logic [ADDR_W-1:0] START    = ADDR_W'(FMAP_W + 1);
    // From the last window of a row: skip the rest of this pixel row and the
    // whole even pixel row below it, landing on column 1 two rows down.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FMAP_W + 2);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(2);

    logic [3:0]        r_row;
    logic [3:0]        r_col;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last;

    assign w_last = (r_row == LAST_RC) && (r_col == LAST_RC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_clear) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= START;
        end else if (i_advance && !w_last) begin
            if (r_col == LAST_RC) begin
                r_col  <= '0;
                r_row  <= r_row + 4'd1;
                r_addr <= r_addr + ROW_STEP;
            end else begin
                r_col  <= r_col + 4'd1;
                r_addr <= r_addr + COL_STEP;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule

// File: rtl/l0_pool_ctrl.sv
// ---------------------------------------------------------------------------
// l0_pool_ctrl
// Layer-0 feature-map RAM sequencer: fills the RAM from the conv-0 stream in
// raster order, then presents the 169 non-overlapping 2x2 windows to pool-0.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame (written to address 0)
// FILL  | accepting pixels 1..675
// SCAN  | presenting windows, advancing on win_valid & win_ready
// DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   i_in_valid/i_in_data     : upstream pixel stream; o_in_ready accepts
//   o_wr/o_addr_wr/o_din     : RAM write port (combinational with acceptance)
//   o_rd/o_addr_rd           : RAM read enable / bottom-right window address
//   o_win_valid/i_win_ready  : window handshake to pool-0
//   o_win_row/o_win_col      : pooled coordinate of the current window
//   o_busy, o_done           : status
//   o_err                    : sticky dropped-pixel flag, only with
//                              L0_POOL_CTRL_ERR_EN defined
// ---------------------------------------------------------------------------
module l0_pool_ctrl #(
    parameter int FMAP_W = cnn_l0_pkg::FMAP_W,
    parameter int DATA_W = cnn_l0_pkg::DATA_W,
    parameter int ADDR_W = cnn_l0_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr_wr,
    output logic [DATA_W-1:0] o_din,
    output logic              o_rd,
    output logic [ADDR_W-1:0] o_addr_rd,
    output logic              o_win_valid,
    input  logic              i_win_ready,
    output logic [3:0]        o_win_row,
    output logic [3:0]        o_win_col,
    output logic              o_busy,
    output logic              o_done
`ifdef L0_POOL_CTRL_ERR_EN
    ,
    output logic              o_err
`endif
);
    import cnn_l0_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(FMAP_W * FMAP_W - 1);

    l0_ctrl_state_t    r_state;
    l0_ctrl_state_t    w_state_nxt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic              w_accept;
    logic              w_fill_end;
    logic              w_advance;
    logic              w_last;
    logic [3:0]        w_row;
    logic [3:0]        w_col;

    assign w_accept   = i_in_valid && o_in_ready;
    assign w_fill_end = w_accept && (r_wr_cnt == LAST_WR);
    assign w_advance  = (r_state == SCAN) && i_win_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)           w_state_nxt = FILL;
            FILL:    if (w_fill_end)         w_state_nxt = SCAN;
            SCAN:    if (w_advance && w_last) w_state_nxt = DONE;
            DONE:                            w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_wr        = 1'b0;
        o_rd        = 1'b0;
        o_win_valid = 1'b0;
        o_busy      = (r_state != IDLE);
        o_done      = 1'b0;
        o_win_row   = '0;
        o_win_col   = '0;
        case (r_state)
            IDLE, FILL: begin
                o_in_ready = 1'b1;
                o_wr       = i_in_valid;
            end
            SCAN: begin
                o_rd        = 1'b1;
                o_win_valid = 1'b1;
                o_win_row   = w_row;
                o_win_col   = w_col;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // Wraps to 0 on the last pixel so IDLE always starts writing at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_accept) begin
            r_wr_cnt <= (r_wr_cnt == LAST_WR) ? '0 : r_wr_cnt + 1'b1;
        end
    end

    assign o_addr_wr = r_wr_cnt;
    assign o_din     = i_in_data;

    l0_pool_addr_gen #(
        .FMAP_W (FMAP_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_fill_end),
        .i_advance (w_advance),
        .o_addr    (o_addr_rd),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

`ifdef L0_POOL_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (i_in_valid && ((r_state == SCAN) || (r_state == DONE))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_l0_pool_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l0_pool_ctrl
// Self-checking bench for l0_pool_ctrl. A behavioural RAM is attached to the
// write port; expected window contents come from the pixel frame the bench
// sent, indexed by pooled coordinate (2r..2r+1, 2c..2c+1).
// Build with L0_POOL_CTRL_ERR_EN to also exercise the sticky error flag.
// ---------------------------------------------------------------------------
module tb_l0_pool_ctrl;

    localparam int FW   = 26;
    localparam int PW   = 13;
    localparam int NPIX = FW * FW;
    localparam int NWIN = PW * PW;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_in_valid;
    logic [17:0] i_in_data;
    logic        o_in_ready;
    logic        o_wr;
    logic [9:0]  o_addr_wr;
    logic [17:0] o_din;
    logic        o_rd;
    logic [9:0]  o_addr_rd;
    logic        o_win_valid;
    logic        i_win_ready;
    logic [3:0]  o_win_row;
    logic [3:0]  o_win_col;
    logic        o_busy;
    logic        o_done;
`ifdef L0_POOL_CTRL_ERR_EN
    logic        o_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit err_exp = 1'b0;

    logic [17:0] mem   [0:NPIX-1];
    logic [17:0] frame [0:NPIX-1];

    always #5 clk = ~clk;

    l0_pool_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_wr        (o_wr),
        .o_addr_wr   (o_addr_wr),
        .o_din       (o_din),
        .o_rd        (o_rd),
        .o_addr_rd   (o_addr_rd),
        .o_win_valid (o_win_valid),
        .i_win_ready (i_win_ready),
        .o_win_row   (o_win_row),
        .o_win_col   (o_win_col),
        .o_busy      (o_busy),
        .o_done      (o_done)
`ifdef L0_POOL_CTRL_ERR_EN
        ,
        .o_err       (o_err)
`endif
    );

    // Behavioural feature-map RAM with combinational read.
    always @(posedge clk) begin
        if (o_wr && (o_addr_wr < 10'(NPIX))) mem[o_addr_wr] <= o_din;
    end

    task automatic test_reset();
        rst = 1'b1;
        i_in_valid = 1'b0; i_in_data = '0; i_win_ready = 1'b0;
        #3;
        n_tests++;
        if (o_in_ready !== 1'b1 || o_wr !== 1'b0 || o_rd !== 1'b0 || o_win_valid !== 1'b0 ||
            o_busy !== 1'b0 || o_done !== 1'b0)
            begin n_fail++; $display("FAIL reset_ctrl: rdy=%b wr=%b rd=%b wv=%b busy=%b done=%b, want 1 0 0 0 0 0",
                                     o_in_ready, o_wr, o_rd, o_win_valid, o_busy, o_done); end
        n_tests++;
        if (o_addr_wr !== 10'd0 || o_addr_rd !== 10'd0 || o_win_row !== 4'd0 || o_win_col !== 4'd0)
            begin n_fail++; $display("FAIL reset_addr: addr_wr=%0d addr_rd=%0d row=%0d col=%0d, want 0 0 0 0",
                                     o_addr_wr, o_addr_rd, o_win_row, o_win_col); end
`ifdef L0_POOL_CTRL_ERR_EN
        n_tests++;
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err); end
`endif
        @(negedge clk); rst = 1'b0; err_exp = 1'b0;
    endtask

    // mode 0: value = address, in_valid held high; mode 1: random data and gaps.
    task automatic fill_frame(input int mode);
        int cnt = 0;
        int guard = 0;
        logic v;
        logic [17:0] d;
        while (cnt < NPIX && guard < 4000) begin
            @(posedge clk); #1;
            v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            d = (mode == 0) ? 18'(cnt) : 18'($urandom);
            i_in_valid = v; i_in_data = d; i_win_ready = 1'($urandom);
            #1;
            n_tests++;
            if (o_in_ready !== 1'b1 || o_wr !== v || o_rd !== 1'b0 || o_busy !== (cnt != 0))
                begin n_fail++; $display("FAIL fill_ctrl[%0d]: rdy=%b wr=%b rd=%b busy=%b, want 1 %b 0 %b",
                                         cnt, o_in_ready, o_wr, o_rd, o_busy, v, (cnt != 0)); end
            if (v) begin
                n_tests++;
                if (o_addr_wr !== 10'(cnt) || o_din !== d)
                    begin n_fail++; $display("FAIL fill_write[%0d]: addr_wr=%0d din=%0d, want %0d %0d",
                                             cnt, o_addr_wr, o_din, cnt, d); end
                frame[cnt] = d;
                cnt++;
            end
            guard++;
        end
        n_tests++;
        if (cnt != NPIX) begin n_fail++; $display("FAIL fill_timeout: accepted %0d want %0d", cnt, NPIX); end
    endtask

    // mode 0: win_ready high; mode 1: random win_ready. Window index st_k is
    // held off for st_len cycles. inj drives one in_valid pulse mid-scan.
    task automatic scan_frame(input int mode, input int st_k, input int st_len, input bit inj);
        int k = 0;
        int cyc = 0;
        int held = 0;
        int r, c, a, ai;
        bit rdy;
        do begin
            @(posedge clk); #1;
            if (k == st_k && held < st_len) begin rdy = 1'b0; held++; end
            else rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            i_win_ready = rdy;
            i_in_valid  = inj && (cyc == 60);
            i_in_data   = 18'($urandom);
            #1;
            r = k / PW; c = k % PW;
            a = (2 * r + 1) * FW + (2 * c + 1);
            n_tests++;
            if (o_rd !== 1'b1 || o_win_valid !== 1'b1 || o_in_ready !== 1'b0 || o_wr !== 1'b0 ||
                o_done !== 1'b0 || o_busy !== 1'b1)
                begin n_fail++; $display("FAIL scan_ctrl[%0d]: rd=%b wv=%b rdy=%b wr=%b done=%b busy=%b, want 1 1 0 0 0 1",
                                         k, o_rd, o_win_valid, o_in_ready, o_wr, o_done, o_busy); end
            n_tests++;
            if (o_addr_rd !== 10'(a) || o_win_row !== 4'(r) || o_win_col !== 4'(c))
                begin n_fail++; $display("FAIL scan_addr[%0d]: addr_rd=%0d row=%0d col=%0d, want %0d %0d %0d",
                                         k, o_addr_rd, o_win_row, o_win_col, a, r, c); end
            ai = int'(o_addr_rd);
            n_tests++;
            if (ai < FW + 1 || ai >= NPIX) begin
                n_fail++; $display("FAIL scan_range[%0d]: addr_rd=%0d want %0d", k, ai, a);
            end else if (mem[ai-FW-1] !== frame[(2*r)*FW + 2*c]   || mem[ai-FW] !== frame[(2*r)*FW + 2*c+1] ||
                         mem[ai-1]    !== frame[(2*r+1)*FW + 2*c] || mem[ai]    !== frame[(2*r+1)*FW + 2*c+1]) begin
                n_fail++; $display("FAIL scan_window[%0d]: got {%0d,%0d,%0d,%0d} want {%0d,%0d,%0d,%0d}", k,
                                   mem[ai-FW-1], mem[ai-FW], mem[ai-1], mem[ai],
                                   frame[(2*r)*FW + 2*c], frame[(2*r)*FW + 2*c+1],
                                   frame[(2*r+1)*FW + 2*c], frame[(2*r+1)*FW + 2*c+1]);
            end
`ifdef L0_POOL_CTRL_ERR_EN
            n_tests++;
            if (o_err !== err_exp) begin n_fail++; $display("FAIL scan_err[%0d]: got %b want %b", k, o_err, err_exp); end
`endif
            if (i_in_valid) err_exp = 1'b1;
            if (rdy) k++;
            cyc++;
        end while (k < NWIN && cyc < 3000);
        n_tests++;
        if (k != NWIN) begin n_fail++; $display("FAIL scan_timeout: windows %0d want %0d", k, NWIN); end

        // Cycle after the last handshake: the done pulse.
        @(posedge clk); #1;
        i_win_ready = 1'b0; i_in_valid = 1'b0;
        #1;
        n_tests++;
        if (o_done !== 1'b1 || o_rd !== 1'b0 || o_win_valid !== 1'b0 || o_busy !== 1'b1 ||
            o_in_ready !== 1'b0 || o_win_row !== 4'd0 || o_win_col !== 4'd0)
            begin n_fail++; $display("FAIL done_pulse: done=%b rd=%b wv=%b busy=%b rdy=%b row=%0d col=%0d, want 1 0 0 1 0 0 0",
                                     o_done, o_rd, o_win_valid, o_busy, o_in_ready, o_win_row, o_win_col); end
        @(posedge clk); #2;
        n_tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1)
            begin n_fail++; $display("FAIL back_to_idle: done=%b busy=%b rdy=%b, want 0 0 1",
                                     o_done, o_busy, o_in_ready); end
`ifdef L0_POOL_CTRL_ERR_EN
        n_tests++;
        if (o_err !== err_exp) begin n_fail++; $display("FAIL idle_err: got %b want %b", o_err, err_exp); end
`endif
    endtask

    task automatic test_fill_scan();
        fill_frame(0);
        scan_frame(0, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        fill_frame(1);
        scan_frame(1, -1, 0, 1'b0);
    endtask

    // Window (3,7) sits at (2*3+1)*26 + (2*7+1) = 197 and must hold for 5 cycles.
    task automatic test_stall();
        fill_frame(0);
        scan_frame(0, 3 * PW + 7, 5, 1'b0);
    endtask

    task automatic test_ignore_valid();
        fill_frame(1);
        scan_frame(0, -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            i_in_valid = 1'b1; i_in_data = 18'($urandom);
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        #1;
        n_tests++;
        if (o_addr_wr !== 10'd300 || o_busy !== 1'b1)
            begin n_fail++; $display("FAIL mid_count: addr_wr=%0d busy=%b, want 300 1", o_addr_wr, o_busy); end
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_addr_wr !== 10'd0 || o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_rd !== 1'b0 || o_done !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset: addr_wr=%0d busy=%b rdy=%b rd=%b done=%b, want 0 0 1 0 0",
                                     o_addr_wr, o_busy, o_in_ready, o_rd, o_done); end
        @(negedge clk); rst = 1'b0; err_exp = 1'b0;
        fill_frame(1);
        scan_frame(0, -1, 0, 1'b0);
    endtask

`ifdef L0_POOL_CTRL_ERR_EN
    task automatic test_err();
        @(negedge clk); rst = 1'b1;
        #1;
        n_tests++;
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", o_err); end
        @(negedge clk); rst = 1'b0; err_exp = 1'b0;
        fill_frame(0);
        scan_frame(0, -1, 0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", o_err); end
        @(negedge clk); rst = 1'b1;
        #1;
        n_tests++;
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_rst: got %b want 0", o_err); end
        @(negedge clk); rst = 1'b0; err_exp = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        i_in_valid = 1'b0; i_in_data = '0; i_win_ready = 1'b0;
        test_reset();
        test_fill_scan();
        test_random();
        test_stall();
        test_ignore_valid();
        test_reset_mid();
`ifdef L0_POOL_CTRL_ERR_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
